alu_multicycle: RTL
===================

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter: WIDTH, 32, operand and result width in bits (legal range 8..64).
REQ-002 Parameter: CNT_W, 7, iteration-counter width; SHALL satisfy 2^CNT_W > WIDTH.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately, independent of clk.
REQ-005 e_start  input  1  request; sampled on the rising edge only while e_busy=0.
REQ-006 e_aluA  input  WIDTH  operand A; captured when a request is accepted.
REQ-007 e_aluB  input  WIDTH  operand B; captured when a request is accepted.
REQ-008 e_alufunc  input  6  operation code; captured when a request is accepted.
REQ-009 e_valE  output  WIDTH  primary result (sum, difference, logic, flag, product low word or quotient).
REQ-010 e_valHi  output  WIDTH  secondary result (product high word or remainder); 0 for single-cycle operations.
REQ-011 e_busy  output  1  high while an iterative operation is in progress.
REQ-012 e_done  output  1  one-cycle pulse marking the cycle in which new results are valid.
REQ-013 e_err  output  1  error flag for an unsupported code or divide-by-zero; valid with e_done.

Function
REQ-014 Op codes: 100000 add (A+B); 100010 sub (B-A); 100100 and; 100101 or; 101010 slt (result 1 if signed A > signed B, else 0, zero-extended); 011001 multu; 011011 divu (A / B).
REQ-015 add/sub SHALL wrap modulo 2^WIDTH; no overflow flag.
REQ-016 FSM states: IDLE, RUN, FIN.
REQ-017 Transitions: IDLE to RUN on an accepted multu/divu with B!=0; IDLE to FIN on any other accepted request; RUN to FIN after WIDTH iterations; FIN to IDLE, or to RUN/FIN if a new request is accepted in FIN.
REQ-018 A request is accepted when e_start=1 and e_busy=0 (IDLE or FIN); e_start while busy SHALL be ignored and not queued.
REQ-019 Single-cycle ops, divu by zero and unsupported codes: request accepted at edge N; results and e_done=1 in the cycle following edge N.
REQ-020 multu: unsigned shift-add, one bit per cycle; e_busy=1 for exactly WIDTH cycles after acceptance; e_done=1 in the following cycle; {e_valHi,e_valE} = full 2*WIDTH-bit product.
REQ-021 divu: unsigned restoring division, one quotient bit per cycle, same latency as multu; e_valE = quotient, e_valHi = remainder.
REQ-022 divu with B=0: no iteration; e_err=1, e_valE = all ones, e_valHi = A.
REQ-023 Unsupported code: e_err=1, e_valE=0, e_valHi=0.
REQ-024 e_valE, e_valHi and e_err SHALL hold their values until the next e_done.
REQ-025 e_done SHALL be high in FIN only, for exactly one cycle per accepted request.
REQ-026 Back-to-back: a request accepted in the e_done cycle SHALL be processed with no idle cycle.
REQ-027 Operand inputs may change freely after acceptance without affecting the result in progress.

Reset
REQ-028 While reset=1: state=IDLE, e_valE=0, e_valHi=0, e_busy=0, e_done=0, e_err=0, counter=0.
REQ-029 Reset asserted during RUN SHALL abort the operation with no e_done pulse; the first accepted request after release SHALL behave normally.

Verification (WIDTH=32)
REQ-030 add A=0xFFFFFFFF, B=0x00000002 -> next cycle e_done=1, e_valE=0x00000001, e_err=0.
REQ-031 slt A=0xFFFFFFFF, B=0x00000001 -> e_valE=0; sub A=5, B=3 -> e_valE=0xFFFFFFFE.
REQ-032 multu A=0xFFFFFFFF, B=0xFFFFFFFF -> e_busy high 32 cycles, then e_done=1, e_valHi=0xFFFFFFFE, e_valE=0x00000001; e_start pulsed mid-RUN is ignored.
REQ-033 divu A=100, B=7 -> after 32 busy cycles e_valE=14, e_valHi=2; divu A=9, B=0 -> next cycle e_err=1, e_valE=0xFFFFFFFF, e_valHi=9.
REQ-034 Unsupported code 111111 -> e_err=1, e_valE=0; a request issued in the e_done cycle completes with no gap.
REQ-035 reset pulsed at RUN iteration 10 of a multu -> all outputs 0 immediately, no e_done; a following add 2+3 -> e_valE=5.

Source files
------------

// File: rtl/alu_multicycle.sv
// Multicycle ALU: single-cycle add/sub/logic/slt, iterative shift-add multu and restoring divu.
// Results land in FIN one cycle after acceptance (single-cycle) or after WIDTH busy cycles (multu/divu).
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             e_start,
  input  logic [WIDTH-1:0] e_aluA,
  input  logic [WIDTH-1:0] e_aluB,
  input  logic [5:0]       e_alufunc,
  output logic [WIDTH-1:0] e_valE,
  output logic [WIDTH-1:0] e_valHi,
  output logic             e_busy,
  output logic             e_done,
  output logic             e_err
);

  localparam logic [5:0] OP_ADD  = 6'b100000;
  localparam logic [5:0] OP_SUB  = 6'b100010;
  localparam logic [5:0] OP_AND  = 6'b100100;
  localparam logic [5:0] OP_OR   = 6'b100101;
  localparam logic [5:0] OP_SLT  = 6'b101010;
  localparam logic [5:0] OP_MULU = 6'b011001;
  localparam logic [5:0] OP_DIVU = 6'b011011;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             is_div;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_lo;

  // Single-cycle results decoded straight from the request inputs.
  logic [WIDTH-1:0] s_val;
  logic [WIDTH-1:0] s_hi;
  logic             s_err;
  logic             s_iter;

  always_comb begin
    s_val  = '0;
    s_hi   = '0;
    s_err  = 1'b0;
    s_iter = 1'b0;
    case (e_alufunc)
      OP_ADD:  s_val = e_aluA + e_aluB;
      OP_SUB:  s_val = e_aluB - e_aluA;
      OP_AND:  s_val = e_aluA & e_aluB;
      OP_OR:   s_val = e_aluA | e_aluB;
      OP_SLT:  s_val = {{(WIDTH-1){1'b0}}, ($signed(e_aluA) > $signed(e_aluB))};
      OP_MULU: s_iter = 1'b1;
      OP_DIVU: begin
        if (e_aluB == '0) begin
          s_err = 1'b1;
          s_val = '1;
          s_hi  = e_aluA;
        end else begin
          s_iter = 1'b1;
        end
      end
      default: s_err = 1'b1;
    endcase
  end

  // One iteration step: multu shifts {carry,hi,lo} right, divu shifts {rem,quo} left.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_r;
  logic [WIDTH:0]   div_d;
  logic             div_ge;
  logic [WIDTH-1:0] nxt_hi;
  logic [WIDTH-1:0] nxt_lo;

  always_comb begin
    mul_sum = {1'b0, w_hi} + (w_lo[0] ? {1'b0, opb} : '0);
    div_r   = {w_hi, w_lo[WIDTH-1]};
    div_d   = div_r - {1'b0, opb};
    div_ge  = ~div_d[WIDTH];
    if (is_div) begin
      nxt_hi = div_ge ? div_d[WIDTH-1:0] : div_r[WIDTH-1:0];
      nxt_lo = {w_lo[WIDTH-2:0], div_ge};
    end else begin
      nxt_hi = mul_sum[WIDTH:1];
      nxt_lo = {mul_sum[0], w_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      is_div  <= 1'b0;
      opb     <= '0;
      w_hi    <= '0;
      w_lo    <= '0;
      e_valE  <= '0;
      e_valHi <= '0;
      e_busy  <= 1'b0;
      e_done  <= 1'b0;
      e_err   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          w_hi <= nxt_hi;
          w_lo <= nxt_lo;
          cnt  <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            state   <= FIN;
            e_busy  <= 1'b0;
            e_done  <= 1'b1;
            e_valE  <= nxt_lo;
            e_valHi <= nxt_hi;
            e_err   <= 1'b0;
          end
        end
        IDLE, FIN: begin
          if (e_start) begin
            if (s_iter) begin
              // Results stay on the outputs untouched while the working regs iterate.
              state  <= RUN;
              e_busy <= 1'b1;
              e_done <= 1'b0;
              cnt    <= '0;
              is_div <= (e_alufunc == OP_DIVU);
              w_hi   <= '0;
              if (e_alufunc == OP_DIVU) begin
                opb  <= e_aluB;
                w_lo <= e_aluA;
              end else begin
                opb  <= e_aluA;
                w_lo <= e_aluB;
              end
            end else begin
              state   <= FIN;
              e_done  <= 1'b1;
              e_valE  <= s_val;
              e_valHi <= s_hi;
              e_err   <= s_err;
            end
          end else begin
            state  <= IDLE;
            e_done <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          e_busy <= 1'b0;
          e_done <= 1'b0;
        end
      endcase
    end
  end

endmodule
